// File: rtl/io_port_bridge.sv
// ---------------------------------------------------------------------------
// io_port_bridge
//
// External-side endpoint of the processor I/O interface. It sits beside the
// core at top level and does three jobs:
//   * Captures every core OUT write into an output FIFO that an external host
//     drains over a valid/ready handshake.
//   * Buffers host words in an input FIFO whose head is presented to the
//     core's In_Port. Each core IN strobe pops one word.
//   * Raises the core's interupt line for INT_PULSE cycles when input data is
//     waiting, then waits for the ISR's read before it can re-arm.
//
// Handshake rule for both host channels: a word moves on a rising clk edge
// exactly when valid and ready are both high at that edge. The sender holds
// data stable while valid is high and ready is low. Ready never depends on
// valid.
//
// Ports
//   clk            in   1       rising-edge clock
//   reset          in   1       asynchronous, active-low reset
//   cpu_out_data   in   DATA_W  core Out_Port value
//   cpu_out_wr     in   1       core OUT strobe, one cycle per write
//   cpu_in_rd      in   1       core IN strobe, one cycle per read (pops input FIFO)
//   cpu_in_data    out  DATA_W  input FIFO head, 0 when empty
//   interupt       out  1       interrupt to core
//   int_en         in   1       interrupt generation enable
//   host_in_data   in   DATA_W  host word for the core
//   host_in_valid  in   1       host_in_data valid
//   host_in_ready  out  1       input FIFO can take a word this edge
//   host_out_data  out  DATA_W  output FIFO head, 0 when empty
//   host_out_valid out  1       output FIFO not empty
//   host_out_ready in   1       host accepts host_out_data
//   ovf_flag       out  1       sticky: core write dropped because output FIFO full
//   unf_flag       out  1       sticky: core read while input FIFO empty
//   int_state      out  2       interrupt FSM state (debug observation)
// ---------------------------------------------------------------------------
module io_port_bridge #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4,
    parameter int INT_PULSE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_out_wr,
    input  logic              cpu_in_rd,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic              interupt,
    input  logic              int_en,
    input  logic [DATA_W-1:0] host_in_data,
    input  logic              host_in_valid,
    output logic              host_in_ready,
    output logic [DATA_W-1:0] host_out_data,
    output logic              host_out_valid,
    input  logic              host_out_ready,
    output logic              ovf_flag,
    output logic              unf_flag,
    output logic [1:0]        int_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    // Pulse-length counter sized for INT_PULSE-1, with a 1-bit floor.
    localparam int PCNT_W = (INT_PULSE > 1) ? $clog2(INT_PULSE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(INT_PULSE - 1);

    // Interrupt FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_SERVE = 2'd2;

    // -----------------------------------------------------------------------
    // Input FIFO: host -> core
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] in_mem [DEPTH];
    logic [PTR_W-1:0]  in_wr_ptr;
    logic [PTR_W-1:0]  in_rd_ptr;
    logic [PTR_W:0]    in_count;
    logic              in_empty;
    logic              in_full;
    logic              in_push;
    logic              in_pop;

    assign in_empty = (in_count == '0);
    assign in_full  = (in_count == FULL_CNT);
    assign in_pop   = cpu_in_rd & ~in_empty;

    // When full, a core read in the same cycle frees the slot the host word
    // lands in, so push and pop both happen and the count holds at DEPTH.
    assign host_in_ready = ~in_full | cpu_in_rd;
    assign in_push       = host_in_valid & host_in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_count  <= '0;
            unf_flag  <= 1'b0;
        end else begin
            if (in_push) begin
                in_wr_ptr <= in_wr_ptr + 1'b1;
            end
            if (in_pop) begin
                in_rd_ptr <= in_rd_ptr + 1'b1;
            end
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + 1'b1;
                2'b01:   in_count <= in_count - 1'b1;
                default: in_count <= in_count;
            endcase
            if (cpu_in_rd && in_empty) begin
                unf_flag <= 1'b1;
            end
        end
    end

    // Storage needs no reset: every read of it is gated by the count.
    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem[in_wr_ptr] <= host_in_data;
        end
    end

    assign cpu_in_data = in_empty ? '0 : in_mem[in_rd_ptr];

    // -----------------------------------------------------------------------
    // Output FIFO: core -> host
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] out_mem [DEPTH];
    logic [PTR_W-1:0]  out_wr_ptr;
    logic [PTR_W-1:0]  out_rd_ptr;
    logic [PTR_W:0]    out_count;
    logic              out_empty;
    logic              out_full;
    logic              out_push;
    logic              out_pop;

    assign out_empty      = (out_count == '0);
    assign out_full       = (out_count == FULL_CNT);
    assign host_out_valid = ~out_empty;
    assign out_pop        = host_out_valid & host_out_ready;

    // A core write into a full FIFO still lands if the host drains the head
    // on the same edge; otherwise the word is lost and ovf_flag latches.
    assign out_push = cpu_out_wr & (~out_full | out_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
            ovf_flag   <= 1'b0;
        end else begin
            if (out_push) begin
                out_wr_ptr <= out_wr_ptr + 1'b1;
            end
            if (out_pop) begin
                out_rd_ptr <= out_rd_ptr + 1'b1;
            end
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + 1'b1;
                2'b01:   out_count <= out_count - 1'b1;
                default: out_count <= out_count;
            endcase
            if (cpu_out_wr && !out_push) begin
                ovf_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (out_push) begin
            out_mem[out_wr_ptr] <= cpu_out_data;
        end
    end

    assign host_out_data = out_empty ? '0 : out_mem[out_rd_ptr];

    // -----------------------------------------------------------------------
    // Interrupt FSM
    //   IDLE  : line low; arms when enabled and input data is waiting.
    //   PULSE : line high for INT_PULSE cycles.
    //   SERVE : line low until the ISR reads In_Port; then back to IDLE,
    //           which guarantees at least one low cycle between pulses.
    // Dropping int_en returns to IDLE on the next edge; data still queued
    // retriggers once it is raised again.
    // -----------------------------------------------------------------------
    logic [1:0]        state;
    logic [PCNT_W-1:0] pulse_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pulse_cnt <= '0;
        end else if (!int_en) begin
            state     <= ST_IDLE;
            pulse_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!in_empty) begin
                        state     <= ST_PULSE;
                        pulse_cnt <= '0;
                    end
                end
                ST_PULSE: begin
                    if (pulse_cnt == PCNT_LAST) begin
                        state <= ST_SERVE;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (cpu_in_rd) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pulse_cnt <= '0;
                end
            endcase
        end
    end

    // Decoded straight from the state register, so the line is glitch-free
    // and falls immediately when reset is asserted.
    assign interupt  = (state == ST_PULSE);
    assign int_state = state;

endmodule

// File: tb/tb_io_port_bridge.sv
module tb_io_port_bridge;

  localparam int DATA_W    = 16;
  localparam int DEPTH     = 4;
  localparam int INT_PULSE = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] cpu_out_data = '0;
  logic              cpu_out_wr = 1'b0;
  logic              cpu_in_rd = 1'b0;
  logic [DATA_W-1:0] cpu_in_data;
  logic              interupt;
  logic              int_en = 1'b0;
  logic [DATA_W-1:0] host_in_data = '0;
  logic              host_in_valid = 1'b0;
  logic              host_in_ready;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_valid;
  logic              host_out_ready = 1'b0;
  logic              ovf_flag;
  logic              unf_flag;
  logic [1:0]        int_state;

  io_port_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INT_PULSE(INT_PULSE)) dut (
    .clk(clk), .reset(reset),
    .cpu_out_data(cpu_out_data), .cpu_out_wr(cpu_out_wr),
    .cpu_in_rd(cpu_in_rd), .cpu_in_data(cpu_in_data),
    .interupt(interupt), .int_en(int_en),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid),
    .host_in_ready(host_in_ready),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready),
    .ovf_flag(ovf_flag), .unf_flag(unf_flag), .int_state(int_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int tests = 0;
  int failed = 0;

  logic [DATA_W-1:0] exp_q[$];     // words the host should see, in order
  logic [DATA_W-1:0] in_q[$];      // words the core should see, in order
  bit m_ovf, m_unf;
  int m_hi_left;                   // remaining high cycles of the current pulse
  bit m_await_read;                // pulse done, waiting for the ISR read

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    in_q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_hi_left = 0;
    m_await_read = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".cpu_in_data"}, 32'(cpu_in_data), (in_q.size() > 0) ? 32'(in_q[0]) : 32'h0);
    check({tag, ".host_in_ready"}, 32'(host_in_ready), 32'(in_q.size() < DEPTH));
    check({tag, ".host_out_valid"}, 32'(host_out_valid), 32'(exp_q.size() > 0));
    check({tag, ".host_out_data"}, 32'(host_out_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
    check({tag, ".interupt"}, 32'(interupt), 32'(m_hi_left > 0));
    check({tag, ".ovf_flag"}, 32'(ovf_flag), 32'(m_ovf));
    check({tag, ".unf_flag"}, 32'(unf_flag), 32'(m_unf));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drop_strobes();
    host_in_valid = 1'b0;
    cpu_in_rd = 1'b0;
    cpu_out_wr = 1'b0;
    host_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drop_strobes();
    int_en = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock: drive inputs, predict with the model, compare after the edge.
  task automatic step(input logic hv, input logic [DATA_W-1:0] hd, input logic rd,
                      input logic ow, input logic [DATA_W-1:0] od, input logic hr,
                      input logic en, input string tag);
    bit in_pop_m, in_take, out_pop_m, out_take;
    host_in_valid = hv; host_in_data = hd; cpu_in_rd = rd;
    cpu_out_wr = ow; cpu_out_data = od; host_out_ready = hr; int_en = en;

    in_pop_m  = rd && (in_q.size() > 0);
    in_take   = hv && ((in_q.size() < DEPTH) || in_pop_m);
    out_pop_m = hr && (exp_q.size() > 0);
    out_take  = ow && ((exp_q.size() < DEPTH) || out_pop_m);
    if (rd && in_q.size() == 0) m_unf = 1;
    if (ow && !out_take) m_ovf = 1;

    // Interrupt behaviour from the pre-edge view of the input queue.
    if (!en) begin
      m_hi_left = 0;
      m_await_read = 0;
    end else if (m_hi_left > 0) begin
      m_hi_left--;
      if (m_hi_left == 0) m_await_read = 1;
    end else if (m_await_read) begin
      if (rd) m_await_read = 0;
    end else if (in_q.size() > 0) begin
      m_hi_left = INT_PULSE;
    end

    @(posedge clk);
    #1;
    drop_strobes();
    if (in_pop_m) void'(in_q.pop_front());
    if (in_take) in_q.push_back(hd);
    if (out_pop_m) void'(exp_q.pop_front());
    if (out_take) exp_q.push_back(od);
    #1;
    compare_model(tag);
  endtask

  task automatic idle(input logic en, input string tag);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, en, tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic              hv;
    logic [DATA_W-1:0] hd;
    logic              rd;
    logic              ow;
    logic [DATA_W-1:0] od;
    logic              hr;
    logic [DATA_W-1:0] e_cid;
    logic              e_hir;
    logic              e_hov;
    logic [DATA_W-1:0] e_hod;
    logic              e_ovf;
    logic              e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic hv, input logic [DATA_W-1:0] hd, input logic rd,
                     input logic ow, input logic [DATA_W-1:0] od, input logic hr,
                     input logic [DATA_W-1:0] e_cid, input logic e_hir, input logic e_hov,
                     input logic [DATA_W-1:0] e_hod, input logic e_ovf, input logic e_unf);
    vec_t v;
    v.hv = hv; v.hd = hd; v.rd = rd; v.ow = ow; v.od = od; v.hr = hr;
    v.e_cid = e_cid; v.e_hir = e_hir; v.e_hov = e_hov; v.e_hod = e_hod;
    v.e_ovf = e_ovf; v.e_unf = e_unf;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    // host pushes two words, core reads them back, then one read too many
    add(1, 16'h0005, 0, 0, 16'h0, 0,  16'h0005, 1, 0, 16'h0000, 0, 0);
    add(1, 16'h0019, 0, 0, 16'h0, 0,  16'h0005, 1, 0, 16'h0000, 0, 0);
    add(0, 16'h0,    1, 0, 16'h0, 0,  16'h0019, 1, 0, 16'h0000, 0, 0);
    add(0, 16'h0,    1, 0, 16'h0, 0,  16'h0000, 1, 0, 16'h0000, 0, 0);
    add(0, 16'h0,    1, 0, 16'h0, 0,  16'h0000, 1, 0, 16'h0000, 0, 1);
    // core writes two words, host drains them
    add(0, 16'h0, 0, 1, 16'hFFFF, 0,  16'h0000, 1, 1, 16'hFFFF, 0, 1);
    add(0, 16'h0, 0, 1, 16'hF320, 0,  16'h0000, 1, 1, 16'hFFFF, 0, 1);
    add(0, 16'h0, 0, 0, 16'h0,    1,  16'h0000, 1, 1, 16'hF320, 0, 1);
    add(0, 16'h0, 0, 0, 16'h0,    1,  16'h0000, 1, 0, 16'h0000, 0, 1);
    // five writes into a four-deep FIFO: fifth dropped, overflow latches
    add(0, 16'h0, 0, 1, 16'hA001, 0,  16'h0000, 1, 1, 16'hA001, 0, 1);
    add(0, 16'h0, 0, 1, 16'hA002, 0,  16'h0000, 1, 1, 16'hA001, 0, 1);
    add(0, 16'h0, 0, 1, 16'hA003, 0,  16'h0000, 1, 1, 16'hA001, 0, 1);
    add(0, 16'h0, 0, 1, 16'hA004, 0,  16'h0000, 1, 1, 16'hA001, 0, 1);
    add(0, 16'h0, 0, 1, 16'hA005, 0,  16'h0000, 1, 1, 16'hA001, 1, 1);
    // write and drain on the same edge while full: both happen
    add(0, 16'h0, 0, 1, 16'hA006, 1,  16'h0000, 1, 1, 16'hA002, 1, 1);
    add(0, 16'h0, 0, 0, 16'h0,    1,  16'h0000, 1, 1, 16'hA003, 1, 1);
    add(0, 16'h0, 0, 0, 16'h0,    1,  16'h0000, 1, 1, 16'hA004, 1, 1);
    add(0, 16'h0, 0, 0, 16'h0,    1,  16'h0000, 1, 1, 16'hA006, 1, 1);
    add(0, 16'h0, 0, 0, 16'h0,    1,  16'h0000, 1, 0, 16'h0000, 1, 1);
    // fill the input FIFO, try a push while full, then push+read while full
    add(1, 16'hB001, 0, 0, 16'h0, 0,  16'hB001, 1, 0, 16'h0000, 1, 1);
    add(1, 16'hB002, 0, 0, 16'h0, 0,  16'hB001, 1, 0, 16'h0000, 1, 1);
    add(1, 16'hB003, 0, 0, 16'h0, 0,  16'hB001, 1, 0, 16'h0000, 1, 1);
    add(1, 16'hB004, 0, 0, 16'h0, 0,  16'hB001, 0, 0, 16'h0000, 1, 1);
    add(1, 16'hBEEF, 0, 0, 16'h0, 0,  16'hB001, 0, 0, 16'h0000, 1, 1);
    add(1, 16'hB005, 1, 0, 16'h0, 0,  16'hB002, 0, 0, 16'h0000, 1, 1);
    add(0, 16'h0,    1, 0, 16'h0, 0,  16'hB003, 1, 0, 16'h0000, 1, 1);
    add(0, 16'h0,    1, 0, 16'h0, 0,  16'hB004, 1, 0, 16'h0000, 1, 1);
    add(0, 16'h0,    1, 0, 16'h0, 0,  16'hB005, 1, 0, 16'h0000, 1, 1);
    add(0, 16'h0,    1, 0, 16'h0, 0,  16'h0000, 1, 0, 16'h0000, 1, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset held with the host offering a word: nothing may be taken.
    reset = 1'b0;
    host_in_valid = 1'b1;
    host_in_data = 16'h1234;
    int_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.cpu_in_data", 32'(cpu_in_data), 32'h0);
    check("rst.host_in_ready", 32'(host_in_ready), 32'h1);
    check("rst.host_out_valid", 32'(host_out_valid), 32'h0);
    check("rst.host_out_data", 32'(host_out_data), 32'h0);
    check("rst.interupt", 32'(interupt), 32'h0);
    check("rst.ovf_flag", 32'(ovf_flag), 32'h0);
    check("rst.unf_flag", 32'(unf_flag), 32'h0);
    do_reset();
    #1;
    check("post_rst.cpu_in_data", 32'(cpu_in_data), 32'h0);

    // Directed table, interrupts disabled.
    build_table();
    foreach (vecs[i]) begin
      host_in_valid = vecs[i].hv; host_in_data = vecs[i].hd; cpu_in_rd = vecs[i].rd;
      cpu_out_wr = vecs[i].ow; cpu_out_data = vecs[i].od; host_out_ready = vecs[i].hr;
      @(posedge clk);
      #1;
      drop_strobes();
      #1;
      check($sformatf("vec%0d.cpu_in_data", i), 32'(cpu_in_data), 32'(vecs[i].e_cid));
      check($sformatf("vec%0d.host_in_ready", i), 32'(host_in_ready), 32'(vecs[i].e_hir));
      check($sformatf("vec%0d.host_out_valid", i), 32'(host_out_valid), 32'(vecs[i].e_hov));
      check($sformatf("vec%0d.host_out_data", i), 32'(host_out_data), 32'(vecs[i].e_hod));
      check($sformatf("vec%0d.ovf_flag", i), 32'(ovf_flag), 32'(vecs[i].e_ovf));
      check($sformatf("vec%0d.unf_flag", i), 32'(unf_flag), 32'(vecs[i].e_unf));
      check($sformatf("vec%0d.interupt", i), 32'(interupt), 32'h0);
    end

    // Flags survive until reset, then clear.
    do_reset();
    #1;
    check("flag_clr.ovf_flag", 32'(ovf_flag), 32'h0);
    check("flag_clr.unf_flag", 32'(unf_flag), 32'h0);

    // Interrupt pulse, serve wait, re-arm after one low cycle.
    step(1, 16'h0005, 0, 0, '0, 0, 1, "irq_push");
    check("irq.low_on_push_edge", 32'(interupt), 32'h0);
    idle(1, "irq_rise");
    check("irq.high", 32'(interupt), 32'h1);
    for (int k = 1; k < INT_PULSE; k++) begin
      idle(1, "irq_hold");
      check("irq.hold", 32'(interupt), 32'h1);
    end
    idle(1, "irq_fall");
    check("irq.fall", 32'(interupt), 32'h0);
    step(1, 16'h0007, 0, 0, '0, 0, 1, "irq_second");
    for (int k = 0; k < 3; k++) begin
      idle(1, "irq_serve_wait");
      check("irq.serve_wait", 32'(interupt), 32'h0);
    end
    step(0, '0, 1, 0, '0, 0, 1, "irq_isr_read");
    check("irq.low_gap", 32'(interupt), 32'h0);
    idle(1, "irq_rearm");
    check("irq.rearm", 32'(interupt), 32'h1);
    // Async reset while the line is high drops it without a clock edge.
    reset = 1'b0;
    #1;
    check("irq.async_reset", 32'(interupt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // int_en low forces the line off; pending data retriggers on re-enable.
    step(1, 16'h0042, 0, 0, '0, 0, 1, "en_push");
    idle(1, "en_rise");
    check("en.high", 32'(interupt), 32'h1);
    idle(0, "en_off");
    check("en.forced_low", 32'(interupt), 32'h0);
    idle(0, "en_off2");
    check("en.stays_low", 32'(interupt), 32'h0);
    idle(1, "en_back");
    check("en.retrigger", 32'(interupt), 32'h1);

    // Full input FIFO: push+read every edge over 2*DEPTH words.
    do_reset();
    for (int k = 0; k < DEPTH; k++) step(1, 16'hC000 + 16'(k), 0, 0, '0, 0, 0, "wrap_fill");
    for (int k = 0; k < 2 * DEPTH; k++)
      step(1, 16'hC100 + 16'(k), 1, 0, '0, 0, 0, "wrap_both");
    for (int k = 0; k < DEPTH + 1; k++) step(0, '0, 1, 0, '0, 0, 0, "wrap_drain");

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 5) != 0), "rand");
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
